// File: rtl/pipe_irq_ctrl.sv
// Purpose : prioritised, vectored multi-channel interrupt entry/return for the 5-stage RV32 pipeline.
// Latency : raw rise to pending in SYNC_STAGES+1 clocks; entry is 1 IDLE + DRAIN_CYCLES drain + 1 vector cycle.
// Backpres: holds fetch while draining; events arriving during service stay pending until the return.
module pipe_irq_ctrl #(
    parameter int              NUM_IRQ      = 4,
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] VEC_BASE     = 32'h0000_0100,
    parameter int              VEC_STRIDE   = 4,
    parameter int              DRAIN_CYCLES = 3,
    parameter int              SYNC_STAGES  = 2,
    localparam int             IDW          = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [NUM_IRQ-1:0] irq_mode,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic [XLEN-1:0]    next_pc_in,
    input  logic               branch_taken_in,
    input  logic [XLEN-1:0]    branch_target_in,
    input  logic               mret,
    output logic               fetch_hold,
    output logic               flush,
    output logic               redirect_valid,
    output logic [XLEN-1:0]    redirect_pc,
    output logic [NUM_IRQ-1:0] irq_ack,
    output logic [IDW-1:0]     irq_id,
    output logic [NUM_IRQ-1:0] pending,
    output logic               in_isr
);

    localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        VECTOR = 2'd2,
        ISR    = 2'd3
    } state_t;

    state_t                              state;
    logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] sync_q;
    logic [NUM_IRQ-1:0]                  sync_d;
    logic [NUM_IRQ-1:0]                  irq_sync;
    logic [NUM_IRQ-1:0]                  irq_edge;
    logic [NUM_IRQ-1:0]                  req;
    logic [XLEN-1:0]                     epc;
    logic [CW-1:0]                       cnt;
    logic [IDW-1:0]                      sel_id;

    assign irq_sync = sync_q[SYNC_STAGES-1];
    assign irq_edge = irq_sync & ~sync_d;
    assign req      = pending & irq_mask;

    // Metastability chain for the raw button inputs, plus a delayed copy for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            sync_d <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], irq_in};
            sync_d <= irq_sync;
        end
    end

    // Edge channels latch until acked (a fresh edge beats the ack); level channels follow the synced input.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= (irq_mode & (irq_edge | (pending & ~irq_ack))) | (~irq_mode & irq_sync);
        end
    end

    // Fixed priority: lowest enabled pending index wins.
    always_comb begin
        sel_id = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                sel_id = IDW'(i);
            end
        end
    end

    // Entry/return sequencer: capture EPC, drain the pipe, vector, then wait for the return pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            epc    <= '0;
            cnt    <= '0;
            irq_id <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        epc    <= next_pc_in;
                        irq_id <= sel_id;
                        cnt    <= CW'(DRAIN_CYCLES - 1);
                        state  <= DRAIN;
                    end
                end
                DRAIN: begin
                    // A branch resolving while draining changes where the interrupted flow resumes.
                    if (branch_taken_in) begin
                        epc <= branch_target_in;
                    end
                    if (cnt == '0) begin
                        state <= VECTOR;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                VECTOR: begin
                    state <= ISR;
                end
                ISR: begin
                    if (mret) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Pipeline control decoded from the state register, qualified by same-cycle branch/mret.
    always_comb begin
        fetch_hold     = (state == DRAIN);
        in_isr         = (state == ISR);
        flush          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        irq_ack        = '0;
        case (state)
            DRAIN: begin
                flush = branch_taken_in;
            end
            VECTOR: begin
                redirect_valid = 1'b1;
                redirect_pc    = VEC_BASE + XLEN'(irq_id) * XLEN'(VEC_STRIDE);
                flush          = 1'b1;
                irq_ack        = NUM_IRQ'(1) << irq_id;
            end
            ISR: begin
                if (mret) begin
                    redirect_valid = 1'b1;
                    redirect_pc    = epc;
                    flush          = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pipe_irq_ctrl.sv
module tb_pipe_irq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  irq_in;
    logic [3:0]  irq_mode;
    logic [3:0]  irq_mask;
    logic [31:0] next_pc_in;
    logic        branch_taken_in;
    logic [31:0] branch_target_in;
    logic        mret;
    logic        fetch_hold;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [3:0]  irq_ack;
    logic [1:0]  irq_id;
    logic [3:0]  pending;
    logic        in_isr;

    int checks = 0;
    int errs   = 0;

    pipe_irq_ctrl dut (
        .clk              (clk),
        .reset            (reset),
        .irq_in           (irq_in),
        .irq_mode         (irq_mode),
        .irq_mask         (irq_mask),
        .next_pc_in       (next_pc_in),
        .branch_taken_in  (branch_taken_in),
        .branch_target_in (branch_target_in),
        .mret             (mret),
        .fetch_hold       (fetch_hold),
        .flush            (flush),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .irq_ack          (irq_ack),
        .irq_id           (irq_id),
        .pending          (pending),
        .in_isr           (in_isr)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        reset = 1'b1; irq_in = '0; irq_mode = '0; irq_mask = '0; next_pc_in = '0;
        branch_taken_in = 1'b0; branch_target_in = '0; mret = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (fetch_hold !== 1'b0) begin errs++; $display("FAIL rst_hold got %b exp 0", fetch_hold); end
        checks++; if (flush !== 1'b0) begin errs++; $display("FAIL rst_flush got %b exp 0", flush); end
        checks++; if (redirect_valid !== 1'b0) begin errs++; $display("FAIL rst_rv got %b exp 0", redirect_valid); end
        checks++; if (redirect_pc !== 32'h0) begin errs++; $display("FAIL rst_rpc got %h exp 0", redirect_pc); end
        checks++; if (irq_ack !== 4'b0) begin errs++; $display("FAIL rst_ack got %b exp 0", irq_ack); end
        checks++; if (irq_id !== 2'd0) begin errs++; $display("FAIL rst_id got %0d exp 0", irq_id); end
        checks++; if (pending !== 4'b0) begin errs++; $display("FAIL rst_pend got %b exp 0", pending); end
        checks++; if (in_isr !== 1'b0) begin errs++; $display("FAIL rst_isr got %b exp 0", in_isr); end
    endtask

    task automatic test_edge_entry();
        do_reset();
        irq_mode = 4'b1111; irq_mask = 4'b0100; next_pc_in = 32'h40;
        irq_in = 4'b0100;
        @(negedge clk); irq_in = '0;
        @(negedge clk);
        checks++; if (pending !== 4'b0000) begin errs++; $display("FAIL edge_pend_early got %b exp 0000", pending); end
        @(negedge clk);
        checks++; if (pending !== 4'b0100) begin errs++; $display("FAIL edge_pend got %b exp 0100", pending); end
        checks++; if (fetch_hold !== 1'b0) begin errs++; $display("FAIL edge_idle_hold got %b exp 0", fetch_hold); end
        @(negedge clk);
        next_pc_in = 32'h44;
        checks++; if (irq_id !== 2'd2) begin errs++; $display("FAIL edge_id got %0d exp 2", irq_id); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (fetch_hold !== 1'b1) begin errs++; $display("FAIL edge_hold%0d got %b exp 1", i, fetch_hold); end
            @(negedge clk);
        end
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h108) begin errs++; $display("FAIL edge_vec got %b/%h exp 1/00000108", redirect_valid, redirect_pc); end
        checks++; if (irq_ack !== 4'b0100 || flush !== 1'b1 || fetch_hold !== 1'b0) begin errs++; $display("FAIL edge_ack got ack=%b flush=%b hold=%b exp 0100/1/0", irq_ack, flush, fetch_hold); end
        @(negedge clk);
        checks++; if (in_isr !== 1'b1 || pending !== 4'b0 || irq_ack !== 4'b0) begin errs++; $display("FAIL edge_isr got isr=%b pend=%b ack=%b exp 1/0000/0000", in_isr, pending, irq_ack); end
        repeat (2) @(negedge clk);
        checks++; if (in_isr !== 1'b1 || redirect_valid !== 1'b0) begin errs++; $display("FAIL edge_isr_hold got isr=%b rv=%b exp 1/0", in_isr, redirect_valid); end
        mret = 1'b1; #1;
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h40 || flush !== 1'b1) begin errs++; $display("FAIL edge_ret got rv=%b pc=%h fl=%b exp 1/00000040/1", redirect_valid, redirect_pc, flush); end
        @(negedge clk); mret = 1'b0; #1;
        checks++; if (in_isr !== 1'b0 || redirect_valid !== 1'b0 || fetch_hold !== 1'b0) begin errs++; $display("FAIL edge_after got isr=%b rv=%b hold=%b exp 0/0/0", in_isr, redirect_valid, fetch_hold); end
    endtask

    task automatic test_priority();
        do_reset();
        irq_mode = 4'b1111; irq_mask = 4'b1111; next_pc_in = 32'h40;
        irq_in = 4'b1010;
        @(negedge clk); irq_in = '0;
        repeat (2) @(negedge clk);
        checks++; if (pending !== 4'b1010) begin errs++; $display("FAIL prio_pend got %b exp 1010", pending); end
        @(negedge clk);
        checks++; if (irq_id !== 2'd1 || fetch_hold !== 1'b1) begin errs++; $display("FAIL prio_id got id=%0d hold=%b exp 1/1", irq_id, fetch_hold); end
        repeat (3) @(negedge clk);
        checks++; if (redirect_pc !== 32'h104 || irq_ack !== 4'b0010) begin errs++; $display("FAIL prio_vec1 got pc=%h ack=%b exp 00000104/0010", redirect_pc, irq_ack); end
        next_pc_in = 32'h200;
        @(negedge clk);
        checks++; if (pending !== 4'b1000 || in_isr !== 1'b1) begin errs++; $display("FAIL prio_retain got pend=%b isr=%b exp 1000/1", pending, in_isr); end
        mret = 1'b1; #1;
        checks++; if (redirect_pc !== 32'h40) begin errs++; $display("FAIL prio_ret1 got %h exp 00000040", redirect_pc); end
        @(negedge clk); mret = 1'b0;
        checks++; if (in_isr !== 1'b0 || fetch_hold !== 1'b0) begin errs++; $display("FAIL prio_gap got isr=%b hold=%b exp 0/0", in_isr, fetch_hold); end
        @(negedge clk);
        checks++; if (fetch_hold !== 1'b1 || irq_id !== 2'd3) begin errs++; $display("FAIL prio_reentry got hold=%b id=%0d exp 1/3", fetch_hold, irq_id); end
        repeat (3) @(negedge clk);
        checks++; if (redirect_pc !== 32'h10C || irq_ack !== 4'b1000) begin errs++; $display("FAIL prio_vec3 got pc=%h ack=%b exp 0000010c/1000", redirect_pc, irq_ack); end
        @(negedge clk);
        mret = 1'b1; #1;
        checks++; if (redirect_pc !== 32'h200 || pending !== 4'b0) begin errs++; $display("FAIL prio_ret2 got pc=%h pend=%b exp 00000200/0000", redirect_pc, pending); end
        @(negedge clk); mret = 1'b0;
        @(negedge clk);
        checks++; if (fetch_hold !== 1'b0 || in_isr !== 1'b0) begin errs++; $display("FAIL prio_quiet got hold=%b isr=%b exp 0/0", fetch_hold, in_isr); end
    endtask

    task automatic test_branch_drain();
        do_reset();
        irq_mode = 4'b0001; irq_mask = 4'b0001; next_pc_in = 32'h40;
        irq_in = 4'b0001;
        @(negedge clk); irq_in = '0;
        repeat (3) @(negedge clk);
        checks++; if (fetch_hold !== 1'b1 || flush !== 1'b0) begin errs++; $display("FAIL br_d1 got hold=%b fl=%b exp 1/0", fetch_hold, flush); end
        @(negedge clk);
        branch_taken_in = 1'b1; branch_target_in = 32'h80; #1;
        checks++; if (flush !== 1'b1 || fetch_hold !== 1'b1) begin errs++; $display("FAIL br_flush got fl=%b hold=%b exp 1/1", flush, fetch_hold); end
        @(negedge clk);
        branch_taken_in = 1'b0; #1;
        checks++; if (flush !== 1'b0 || fetch_hold !== 1'b1) begin errs++; $display("FAIL br_d3 got fl=%b hold=%b exp 0/1", flush, fetch_hold); end
        @(negedge clk);
        checks++; if (redirect_pc !== 32'h100 || irq_ack !== 4'b0001) begin errs++; $display("FAIL br_vec got pc=%h ack=%b exp 00000100/0001", redirect_pc, irq_ack); end
        @(negedge clk);
        mret = 1'b1; #1;
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h80) begin errs++; $display("FAIL br_ret got rv=%b pc=%h exp 1/00000080", redirect_valid, redirect_pc); end
        @(negedge clk); mret = 1'b0;
    endtask

    task automatic test_level();
        do_reset();
        irq_mode = 4'b0000; irq_mask = 4'b0001; next_pc_in = 32'h40;
        irq_in = 4'b0001;
        repeat (3) @(negedge clk);
        checks++; if (pending !== 4'b0001) begin errs++; $display("FAIL lvl_pend got %b exp 0001", pending); end
        repeat (4) @(negedge clk);
        checks++; if (redirect_pc !== 32'h100 || irq_ack !== 4'b0001) begin errs++; $display("FAIL lvl_vec got pc=%h ack=%b exp 00000100/0001", redirect_pc, irq_ack); end
        @(negedge clk);
        checks++; if (in_isr !== 1'b1 || pending !== 4'b0001) begin errs++; $display("FAIL lvl_noclr got isr=%b pend=%b exp 1/0001", in_isr, pending); end
        mret = 1'b1;
        @(negedge clk); mret = 1'b0;
        checks++; if (in_isr !== 1'b0 || fetch_hold !== 1'b0) begin errs++; $display("FAIL lvl_gap got isr=%b hold=%b exp 0/0", in_isr, fetch_hold); end
        @(negedge clk);
        checks++; if (fetch_hold !== 1'b1) begin errs++; $display("FAIL lvl_reentry got %b exp 1", fetch_hold); end
        repeat (4) @(negedge clk);
        irq_in = '0;
        repeat (3) @(negedge clk);
        checks++; if (pending !== 4'b0000 || in_isr !== 1'b1) begin errs++; $display("FAIL lvl_drop got pend=%b isr=%b exp 0000/1", pending, in_isr); end
        mret = 1'b1;
        @(negedge clk); mret = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (fetch_hold !== 1'b0 || in_isr !== 1'b0) begin errs++; $display("FAIL lvl_stay%0d got hold=%b isr=%b exp 0/0", i, fetch_hold, in_isr); end
        end
    endtask

    task automatic test_mask_simul();
        do_reset();
        irq_mode = 4'b1111; irq_mask = 4'b0000; next_pc_in = 32'h40;
        irq_in = 4'b0100;
        @(negedge clk); irq_in = '0;
        repeat (4) @(negedge clk);
        checks++; if (pending !== 4'b0100 || fetch_hold !== 1'b0 || in_isr !== 1'b0) begin errs++; $display("FAIL msk_block got pend=%b hold=%b isr=%b exp 0100/0/0", pending, fetch_hold, in_isr); end
        irq_mask = 4'b0100;
        @(negedge clk);
        checks++; if (fetch_hold !== 1'b1) begin errs++; $display("FAIL msk_unmask got %b exp 1", fetch_hold); end
        @(negedge clk);
        irq_mask = 4'b0000; irq_in = 4'b0100;
        @(negedge clk);
        irq_in = '0;
        checks++; if (fetch_hold !== 1'b1) begin errs++; $display("FAIL msk_noabort got %b exp 1", fetch_hold); end
        @(negedge clk);
        checks++; if (irq_ack !== 4'b0100 || redirect_pc !== 32'h108) begin errs++; $display("FAIL msk_vec got ack=%b pc=%h exp 0100/00000108", irq_ack, redirect_pc); end
        @(negedge clk);
        checks++; if (pending !== 4'b0100) begin errs++; $display("FAIL msk_setwins got %b exp 0100", pending); end
        mret = 1'b1;
        @(negedge clk); mret = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (fetch_hold !== 1'b0 || pending !== 4'b0100) begin errs++; $display("FAIL msk_after got hold=%b pend=%b exp 0/0100", fetch_hold, pending); end
    endtask

    task automatic test_reset_isr();
        do_reset();
        irq_mode = 4'b1111; irq_mask = 4'b0100; next_pc_in = 32'h40;
        irq_in = 4'b0100;
        @(negedge clk); irq_in = '0;
        repeat (7) @(negedge clk);
        checks++; if (in_isr !== 1'b1 || irq_id !== 2'd2) begin errs++; $display("FAIL rsti_pre got isr=%b id=%0d exp 1/2", in_isr, irq_id); end
        #2; reset = 1'b1; mret = 1'b1; #1;
        checks++; if (in_isr !== 1'b0 || redirect_valid !== 1'b0 || redirect_pc !== 32'h0 || flush !== 1'b0) begin errs++; $display("FAIL rsti_async got isr=%b rv=%b pc=%h fl=%b exp 0/0/0/0", in_isr, redirect_valid, redirect_pc, flush); end
        checks++; if (irq_id !== 2'd0 || pending !== 4'b0 || fetch_hold !== 1'b0 || irq_ack !== 4'b0) begin errs++; $display("FAIL rsti_regs got id=%0d pend=%b hold=%b ack=%b exp 0/0000/0/0000", irq_id, pending, fetch_hold, irq_ack); end
        @(negedge clk); reset = 1'b0;
        @(negedge clk); mret = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (redirect_valid !== 1'b0 || in_isr !== 1'b0 || fetch_hold !== 1'b0) begin errs++; $display("FAIL rsti_post%0d got rv=%b isr=%b hold=%b exp 0/0/0", i, redirect_valid, in_isr, fetch_hold); end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_edge_entry();
        test_priority();
        test_branch_drain();
        test_level();
        test_mask_simul();
        test_reset_isr();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
        $finish;
    end

endmodule

// File: doc/pipe_irq_ctrl.md
Name: pipe_irq_ctrl

Overview:
- Multi-channel interrupt controller for the 5-stage pipelined RV32 core; successor to the single-button PC interrupt logic.
- Generalised to NUM_IRQ sources, each with its own edge/level mode and mask, plus fixed priority and vectored entry.
- Drains the pipeline before entry, saves the return PC (EPC), and returns on an MRET pulse.
- Sits beside the PC register: drives fetch hold, flush and PC redirect.

Parameters:
- NUM_IRQ, 4, number of interrupt sources (1..16)
- XLEN, 32, PC width
- VEC_BASE, 32'h0000_0100, address of the channel-0 handler
- VEC_STRIDE, 4, byte spacing between per-channel vectors
- DRAIN_CYCLES, 3, cycles fetch is held so in-flight instructions retire (>=1)
- SYNC_STAGES, 2, synchroniser depth for raw inputs (>=2)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- irq_in  in  NUM_IRQ  raw asynchronous sources (buttons)
- irq_mode  in  NUM_IRQ  per channel: 1 = rising-edge, 0 = level-high
- irq_mask  in  NUM_IRQ  per channel: 1 = enabled
- next_pc_in  in  XLEN  PC the fetch stage would load next
- branch_taken_in  in  1  taken branch/jump resolving this cycle
- branch_target_in  in  XLEN  its target
- mret  in  1  one-cycle pulse when a return-from-interrupt executes
- fetch_hold  out  1  freeze PC and insert bubbles into IF/ID
- flush  out  1  squash IF/ID and ID/EX this cycle
- redirect_valid  out  1  load redirect_pc into PC this cycle
- redirect_pc  out  XLEN  redirect target
- irq_ack  out  NUM_IRQ  one-hot one-cycle pulse for the accepted channel
- irq_id  out  $clog2(NUM_IRQ) (min 1)  channel being serviced
- pending  out  NUM_IRQ  pending register
- in_isr  out  1  handler active (drives iled)

Behaviour:
- Reset, asynchronous: every output, the synchronisers, pending, epc, the drain counter and state go to 0; state goes to IDLE. Reset mid-drain or mid-ISR abandons service with no redirect.
- Synchronise each irq_in through SYNC_STAGES flops. Edge = sync & ~sync_d.
- Pending update:
  - Edge channel: pending set on edge; cleared on its own irq_ack. If an edge and the ack land in the same cycle, the set wins.
  - Level channel: pending = synced level; ack does not clear it.
  - Capture runs in every state; mask affects acceptance only.
- Latency: raw rise → pending=1 after SYNC_STAGES+1 clocks.
- Selection: lowest index with pending & irq_mask wins. Priority is evaluated only in IDLE; no nesting.
- FSM:
  - IDLE:
    - If any pending & irq_mask: epc<=next_pc_in, latch irq_id, cnt<=DRAIN_CYCLES-1, go to DRAIN.
    - The mret pulse is ignored.
  - DRAIN:
    - fetch_hold=1.
    - If branch_taken_in: epc<=branch_target_in, flush=1 that cycle.
    - cnt==0 → VECTOR, else cnt--.
    - mret is ignored.
  - VECTOR, one cycle:
    - redirect_valid=1, redirect_pc=VEC_BASE+irq_id*VEC_STRIDE (XLEN arithmetic, wraps), flush=1, irq_ack[irq_id]=1.
    - Go to ISR.
  - ISR:
    - in_isr=1.
    - On mret: redirect_valid=1, redirect_pc=epc, flush=1, go to IDLE.
    - New edges stay pending. A level source still high at return re-enters after one IDLE cycle.
- fetch_hold, flush and redirect_valid are registered-state decodes, valid the same cycle as the state.
- Masking a channel during DRAIN does not abort entry.

Test Plan:
- Edge entry: mode=1, mask=1 on ch2, pulse irq_in[2], next_pc_in=0x40 → pending[2] after 3 clocks, fetch_hold for 3 cycles, then redirect_pc=0x108 with irq_ack=4'b0100, in_isr=1; mret → redirect_pc=0x40, in_isr=0.
- Priority and pending retention: ch1 and ch3 rise together → ch1 serviced (0x104). ch3 stays pending and is serviced one cycle after mret (0x10C).
- Branch during drain: branch_taken_in with target 0x80 on the second DRAIN cycle → flush=1 that cycle; mret later redirects to 0x80.
- Level mode: ch0 mode=0 held high through mret → re-entry after one IDLE cycle. Deassert before mret → returns to IDLE and stays.
- Mask and simultaneous events:
  - Masked ch2 edge → pending[2]=1, no entry.
  - Unmask → entry.
  - New edge on the cycle of its ack → pending stays 1.
- Reset in ISR: assert reset while in_isr=1 → all outputs 0 immediately with no clock edge; no redirect after release.
